cw305_status_monitor: RTL and testbench
=======================================

# cw305_status_monitor

Parametrised board-status and trigger-monitor block for CW305 target designs, the next generation of the single heartbeat counter in the designstart top level. Drives a heartbeat LED, N stretched activity LEDs with synchronised inputs, and measures the length of each capture-trigger pulse in clock cycles. All LED activity can be frozen while the trigger is high to minimise switching noise during capture. Sits in the top level beside the register front end; `trig_cycles` is intended for a `reg_main` read register.

## Interface
- `pCOUNT_WIDTH`, 23: heartbeat counter width; heartbeat LED period is 2^pCOUNT_WIDTH cycles.
- `pCHANNELS`, 3: number of activity channels.
- `pSTRETCH_WIDTH`, 20: activity stretch counter width; stretch length is 2^pSTRETCH_WIDTH−1 cycles.
- `pSYNC_STAGES`, 2: synchroniser depth on `act_in`, ≥2.
- `pTRIG_CNT_WIDTH`, 32: trigger-length counter width.

Ports:
- `ext_clock` in 1: the single clock.
- `fpga_reset` in 1: reset, synchronous, active-high.
- `trig_in` in 1: capture trigger (core GPIO), synchronous to `ext_clock`.
- `act_in` in pCHANNELS: asynchronous activity signals, e.g. UART rxd/txd.
- `heartbeat` out 1: `count[pCOUNT_WIDTH-1]`.
- `act_led` out pCHANNELS: per-channel stretched activity indicator.
- `trig_cycles` out pTRIG_CNT_WIDTH: length of the last completed trigger pulse.
- `trig_valid` out 1: one-cycle strobe when `trig_cycles` updates.
- `trig_overflow` out 1: sticky flag; a measured pulse saturated.

## Operation
- **Reset** (sync, one cycle is enough). All of the following clear to 0:
  - `count`, all stretch counters, pending flags, synchroniser flops, `trig_d`, `run_cnt`.
  - `trig_cycles`, `trig_valid`, `trig_overflow`.
  - Consequently `heartbeat` and `act_led` are 0.
- **freeze** = `trig_in` when `CW305_LED_FREEZE_EN` is defined, else constant 0.
- **Heartbeat**
  - `count <= count + 1` each cycle when freeze is 0; holds otherwise.
  - Wraps modulo 2^pCOUNT_WIDTH.
- **Activity channel i**
  - `act_in[i]` passes through pSYNC_STAGES flops, then one more flop for edge detection.
  - `edge_i` = either edge of the synchronised signal.
  - When freeze is 0:
    - If `edge_i` or `pend_i` is set: load stretch counter with all-ones and clear `pend_i`.
    - Otherwise, if the counter is nonzero: decrement it.
  - When freeze is 1: the counter holds; `edge_i` sets sticky `pend_i`.
  - `act_led[i]` = (counter ≠ 0), registered. An edge while already lit reloads the counter, so the channel stays lit.
- **Trigger measurement** (never frozen)
  - `trig_d` registers `trig_in`.
  - When `trig_in`=1 and `trig_d`=0: `run_cnt <= 1`.
  - When `trig_in`=1 and `trig_d`=1: `run_cnt <= run_cnt + 1`, saturating at all-ones.
  - When `trig_in`=0 and `trig_d`=1:
    - `trig_cycles <= run_cnt`; `trig_valid <= 1`.
    - If `run_cnt` is all-ones, set `trig_overflow`.
  - `trig_valid` is 0 in every other cycle.
  - `trig_overflow` clears only on reset.

## Timing
- `heartbeat` toggles every 2^(pCOUNT_WIDTH−1) unfrozen cycles.
- Activity latency:
  - `act_in` edge to `act_led` rising: pSYNC_STAGES+2 cycles, with ±1 cycle for asynchronous sampling.
  - After the last edge, `act_led` stays high for 2^pSTRETCH_WIDTH−1 unfrozen cycles.
- Freeze boundary:
  - Counters hold starting in the cycle `trig_in` is first sampled high.
  - They resume in the first cycle `trig_in` is sampled low.
  - A pending edge reloads its stretch counter in that first resume cycle.
- Trigger measurement:
  - For a pulse sampled high on N consecutive edges, `trig_cycles`=N and `trig_valid`=1 in the cycle after the first low sample.
  - A minimum pulse (N=1) gives `trig_cycles`=1.
  - Back-to-back pulses with a 1-cycle low gap are each reported.
- Reset while `trig_in`=1: no `trig_valid` is issued for the interrupted pulse. If `trig_in` is still high after reset, the first sample is treated as a rising edge and `run_cnt` starts at 1.

## Configuration
- `CW305_LED_FREEZE_EN`
  - Defined: heartbeat and activity stretch counters freeze while `trig_in`=1, and edges are captured as pending.
  - Not defined: freeze is tied to 0. All LED logic free-runs, `pend_i` is optimised away, and trigger measurement is unchanged.

## Test plan
- Reset, then 2^pCOUNT_WIDTH cycles with `trig_in`=0 (pCOUNT_WIDTH=4) → `heartbeat` rises at cycle 8 and falls at 16; all outputs are 0 during reset.
- `trig_in` high for 5 cycles, then low → `trig_cycles`=5 with a single-cycle `trig_valid`; repeat with 1 cycle high → `trig_cycles`=1.
- pTRIG_CNT_WIDTH=4, `trig_in` high for 20 cycles → `trig_cycles`=15, `trig_overflow`=1 and remaining 1 after a later 3-cycle pulse reports 3.
- pSTRETCH_WIDTH=3, single edge on `act_in[0]` → `act_led[0]` high 3–4 cycles later for exactly 7 cycles; a second edge mid-stretch extends it to 7 cycles after that edge.
- With `CW305_LED_FREEZE_EN`: `trig_in` high for 10 cycles while `act_in[1]` toggles → `count` and `act_led` remain constant; `act_led[1]` lights on the first unfrozen cycle. Without the macro: `count` advances by 10.
- Assert `fpga_reset` during a 10-cycle trigger pulse at cycle 4 → no `trig_valid` for that pulse; the remaining high cycles are reported as a new pulse.

Source files
------------

// File: rtl/cw305_status_monitor.sv
// Board status monitor: heartbeat LED, stretched activity LEDs and trigger-pulse length measurement.
// Optional: define CW305_LED_FREEZE_EN to freeze all LED activity while trig_in is high.
module cw305_status_monitor #(
    parameter int pCOUNT_WIDTH    = 23,
    parameter int pCHANNELS       = 3,
    parameter int pSTRETCH_WIDTH  = 20,
    parameter int pSYNC_STAGES    = 2,
    parameter int pTRIG_CNT_WIDTH = 32
) (
    input  logic                       ext_clock,
    input  logic                       fpga_reset,
    input  logic                       trig_in,
    input  logic [pCHANNELS-1:0]       act_in,
    output logic                       heartbeat,
    output logic [pCHANNELS-1:0]       act_led,
    output logic [pTRIG_CNT_WIDTH-1:0] trig_cycles,
    output logic                       trig_valid,
    output logic                       trig_overflow
);

    localparam logic [pCOUNT_WIDTH-1:0]    COUNT_ONE   = pCOUNT_WIDTH'(1);
    localparam logic [pSTRETCH_WIDTH-1:0]  STRETCH_ONE = pSTRETCH_WIDTH'(1);
    localparam logic [pTRIG_CNT_WIDTH-1:0] TRIG_ONE    = pTRIG_CNT_WIDTH'(1);

    logic                       freeze;
    logic [pCOUNT_WIDTH-1:0]    count;
    logic [pCHANNELS-1:0]       sync_q [pSYNC_STAGES];
    logic [pCHANNELS-1:0]       sync_d;
    logic [pCHANNELS-1:0]       act_edge;
    logic [pCHANNELS-1:0]       pend;
    logic [pSTRETCH_WIDTH-1:0]  stretch [pCHANNELS];
    logic                       trig_d;
    logic [pTRIG_CNT_WIDTH-1:0] run_cnt;

`ifdef CW305_LED_FREEZE_EN
    assign freeze = trig_in;

    // Edges seen while frozen are remembered and replayed on the first resume cycle.
    always_ff @(posedge ext_clock) begin
        if (fpga_reset) begin
            pend <= '0;
        end else if (freeze) begin
            pend <= pend | act_edge;
        end else begin
            pend <= '0;
        end
    end
`else
    assign freeze = 1'b0;
    assign pend   = '0;
`endif

    always_ff @(posedge ext_clock) begin
        if (fpga_reset) begin
            count <= '0;
        end else if (!freeze) begin
            count <= count + COUNT_ONE;
        end
    end

    assign heartbeat = count[pCOUNT_WIDTH-1];

    always_ff @(posedge ext_clock) begin
        if (fpga_reset) begin
            for (int s = 0; s < pSYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_d <= '0;
        end else begin
            sync_q[0] <= act_in;
            for (int s = 1; s < pSYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_d <= sync_q[pSYNC_STAGES-1];
        end
    end

    assign act_edge = sync_q[pSYNC_STAGES-1] ^ sync_d;

    // Any edge (or replayed pending edge) restarts the stretch so a busy channel stays lit.
    always_ff @(posedge ext_clock) begin
        if (fpga_reset) begin
            for (int i = 0; i < pCHANNELS; i++) begin
                stretch[i] <= '0;
            end
            act_led <= '0;
        end else begin
            for (int i = 0; i < pCHANNELS; i++) begin
                if (!freeze) begin
                    if (act_edge[i] || pend[i]) begin
                        stretch[i] <= '1;
                    end else if (stretch[i] != '0) begin
                        stretch[i] <= stretch[i] - STRETCH_ONE;
                    end
                end
                act_led[i] <= (stretch[i] != '0);
            end
        end
    end

    // Pulse length counts sampled-high edges and saturates instead of wrapping.
    always_ff @(posedge ext_clock) begin
        if (fpga_reset) begin
            trig_d        <= 1'b0;
            run_cnt       <= '0;
            trig_cycles   <= '0;
            trig_valid    <= 1'b0;
            trig_overflow <= 1'b0;
        end else begin
            trig_d     <= trig_in;
            trig_valid <= 1'b0;
            if (trig_in && !trig_d) begin
                run_cnt <= TRIG_ONE;
            end else if (trig_in && trig_d) begin
                if (run_cnt != '1) begin
                    run_cnt <= run_cnt + TRIG_ONE;
                end
            end else if (!trig_in && trig_d) begin
                trig_cycles <= run_cnt;
                trig_valid  <= 1'b1;
                if (run_cnt == '1) begin
                    trig_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cw305_status_monitor.sv
// Directed bench for cw305_status_monitor with small parameters (4-bit heartbeat, 3-bit stretch, 4-bit trigger counter).
module tb_cw305_status_monitor;

    logic       ext_clock = 1'b0;
    logic       fpga_reset;
    logic       trig_in;
    logic [2:0] act_in;
    logic       heartbeat;
    logic [2:0] act_led;
    logic [3:0] trig_cycles;
    logic       trig_valid;
    logic       trig_overflow;

    int checks   = 0;
    int failures = 0;

    cw305_status_monitor #(
        .pCOUNT_WIDTH   (4),
        .pCHANNELS      (3),
        .pSTRETCH_WIDTH (3),
        .pSYNC_STAGES   (2),
        .pTRIG_CNT_WIDTH(4)
    ) dut (
        .ext_clock    (ext_clock),
        .fpga_reset   (fpga_reset),
        .trig_in      (trig_in),
        .act_in       (act_in),
        .heartbeat    (heartbeat),
        .act_led      (act_led),
        .trig_cycles  (trig_cycles),
        .trig_valid   (trig_valid),
        .trig_overflow(trig_overflow)
    );

    always #5 ext_clock = ~ext_clock;

    task automatic tick();
        @(posedge ext_clock);
        #1;
    endtask

    task automatic do_reset();
        fpga_reset = 1'b1;
        trig_in    = 1'b0;
        act_in     = 3'b000;
        tick();
        tick();
        fpga_reset = 1'b0;
    endtask

    task automatic test_reset();
        fpga_reset = 1'b1;
        trig_in    = 1'b1;
        act_in     = 3'b101;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({heartbeat, act_led, trig_cycles, trig_valid, trig_overflow} !== 10'd0) begin
                failures++;
                $display("[TB] FAIL reset_outputs k=%0d got hb=%b led=%b cyc=%0d v=%b ovf=%b exp all 0",
                         k, heartbeat, act_led, trig_cycles, trig_valid, trig_overflow);
            end
        end
    endtask

    task automatic test_heartbeat();
        logic exp_hb;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_hb = (k >= 8 && k <= 15);
            checks++;
            if (heartbeat !== exp_hb) begin
                failures++;
                $display("[TB] FAIL heartbeat k=%0d got=%b exp=%b", k, heartbeat, exp_hb);
            end
        end
    endtask

    task automatic test_trigger();
        int lens [2] = '{5, 1};
        logic [3:0] exp_cyc [2] = '{4'd5, 4'd1};
        do_reset();
        for (int p = 0; p < 2; p++) begin
            trig_in = 1'b1;
            for (int k = 0; k < lens[p]; k++) begin
                tick();
                checks++;
                if (trig_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL trig_valid_high p=%0d k=%0d got=%b exp=0", p, k, trig_valid);
                end
            end
            trig_in = 1'b0;
            tick();
            checks++;
            if ({trig_valid, trig_cycles, trig_overflow} !== {1'b1, exp_cyc[p], 1'b0}) begin
                failures++;
                $display("[TB] FAIL trig_report p=%0d got v=%b cyc=%0d ovf=%b exp v=1 cyc=%0d ovf=0",
                         p, trig_valid, trig_cycles, trig_overflow, exp_cyc[p]);
            end
            tick();
            checks++;
            if (trig_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL trig_valid_single p=%0d got=%b exp=0", p, trig_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        trig_in = 1'b1;
        tick();
        tick();
        trig_in = 1'b0;
        tick();
        checks++;
        if ({trig_valid, trig_cycles} !== {1'b1, 4'd2}) begin
            failures++;
            $display("[TB] FAIL b2b_first got v=%b cyc=%0d exp v=1 cyc=2", trig_valid, trig_cycles);
        end
        trig_in = 1'b1;
        tick();
        checks++;
        if (trig_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_gap_valid got=%b exp=0", trig_valid);
        end
        tick();
        tick();
        trig_in = 1'b0;
        tick();
        checks++;
        if ({trig_valid, trig_cycles} !== {1'b1, 4'd3}) begin
            failures++;
            $display("[TB] FAIL b2b_second got v=%b cyc=%0d exp v=1 cyc=3", trig_valid, trig_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        trig_in = 1'b1;
        repeat (20) tick();
        trig_in = 1'b0;
        tick();
        checks++;
        if ({trig_valid, trig_cycles, trig_overflow} !== {1'b1, 4'd15, 1'b1}) begin
            failures++;
            $display("[TB] FAIL sat_report got v=%b cyc=%0d ovf=%b exp v=1 cyc=15 ovf=1",
                     trig_valid, trig_cycles, trig_overflow);
        end
        tick();
        trig_in = 1'b1;
        repeat (3) tick();
        trig_in = 1'b0;
        tick();
        checks++;
        if ({trig_valid, trig_cycles, trig_overflow} !== {1'b1, 4'd3, 1'b1}) begin
            failures++;
            $display("[TB] FAIL sat_sticky got v=%b cyc=%0d ovf=%b exp v=1 cyc=3 ovf=1",
                     trig_valid, trig_cycles, trig_overflow);
        end
    endtask

    // Runs directly after test_saturation so the sticky overflow is set on entry.
    task automatic test_reset_mid_pulse();
        trig_in = 1'b1;
        repeat (3) tick();
        fpga_reset = 1'b1;
        tick();
        fpga_reset = 1'b0;
        checks++;
        if ({trig_valid, trig_cycles, trig_overflow} !== 6'd0) begin
            failures++;
            $display("[TB] FAIL midreset_clear got v=%b cyc=%0d ovf=%b exp all 0",
                     trig_valid, trig_cycles, trig_overflow);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (trig_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_no_valid k=%0d got=%b exp=0", k, trig_valid);
            end
        end
        trig_in = 1'b0;
        tick();
        checks++;
        if ({trig_valid, trig_cycles, trig_overflow} !== {1'b1, 4'd6, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midreset_report got v=%b cyc=%0d ovf=%b exp v=1 cyc=6 ovf=0",
                     trig_valid, trig_cycles, trig_overflow);
        end
    endtask

    task automatic test_activity();
        logic [2:0] exp_led;
        do_reset();
        tick();
        tick();
        act_in = 3'b001;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_led = (k >= 4 && k <= 16) ? 3'b001 : 3'b000;
            checks++;
            if (act_led !== exp_led) begin
                failures++;
                $display("[TB] FAIL act_stretch k=%0d got=%b exp=%b", k, act_led, exp_led);
            end
            if (k == 6) act_in = 3'b000;
        end
    endtask

    task automatic test_freeze();
        logic       exp_hb;
        logic [2:0] exp_led;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            tick();
`ifdef CW305_LED_FREEZE_EN
            exp_hb  = (k >= 18);
            exp_led = (k >= 14) ? 3'b010 : 3'b000;
`else
            exp_hb  = (k >= 8 && k <= 15);
            exp_led = (k >= 7 && k <= 17) ? 3'b010 : 3'b000;
`endif
            checks++;
            if ({heartbeat, act_led} !== {exp_hb, exp_led}) begin
                failures++;
                $display("[TB] FAIL freeze_leds k=%0d got hb=%b led=%b exp hb=%b led=%b",
                         k, heartbeat, act_led, exp_hb, exp_led);
            end
            checks++;
            if (trig_valid !== (k == 13) || (k == 13 && trig_cycles !== 4'd10)) begin
                failures++;
                $display("[TB] FAIL freeze_trig k=%0d got v=%b cyc=%0d exp v=%b cyc=10",
                         k, trig_valid, trig_cycles, (k == 13));
            end
            case (k)
                2:       trig_in = 1'b1;
                3:       act_in  = 3'b010;
                7:       act_in  = 3'b000;
                12:      trig_in = 1'b0;
                default: ;
            endcase
        end
    endtask

    initial begin
        fpga_reset = 1'b1;
        trig_in    = 1'b0;
        act_in     = 3'b000;
        test_reset();
        test_heartbeat();
        test_trigger();
        test_back_to_back();
        test_saturation();
        test_reset_mid_pulse();
        test_activity();
        test_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
